// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file for the pipelined datapath.
// Three combinational read ports, two clocked write ports (port B wins on
// an address collision), optional same-cycle write-to-read forwarding, a
// hardwired zero register and a per-register busy scoreboard that decode
// uses to spot RAW hazards.
module regfile_mp #(
    parameter int N        = 64,
    parameter int REGS     = 32,
    parameter int AW       = $clog2(REGS),
    parameter int ZR       = REGS - 1,
    parameter int BYPASS   = 1,
    parameter int INIT_IDX = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [AW-1:0] ra3,
    output logic [N-1:0]  rd1,
    output logic [N-1:0]  rd2,
    output logic [N-1:0]  rd3,
    output logic          busy1,
    output logic          busy2,
    output logic          busy3,
    input  logic          we3,
    input  logic [AW-1:0] wa3,
    input  logic [N-1:0]  wd3,
    input  logic          we4,
    input  logic [AW-1:0] wa4,
    input  logic [N-1:0]  wd4,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_a
);

    localparam logic [AW-1:0] ZR_A = AW'(ZR);

    logic [N-1:0]    regs [REGS];
    logic [REGS-1:0] sb;
    logic            wr3_ok;
    logic            wr4_ok;
    logic            iss_ok;

    // A write held during reset is discarded, so it must not be forwarded either;
    // that keeps the outputs equal to the reset contents while reset is high.
    assign wr3_ok = we3 && (wa3 != ZR_A) && !reset;
    assign wr4_ok = we4 && (wa4 != ZR_A) && !reset;
    assign iss_ok = iss_en && (iss_a != ZR_A);

    function automatic logic [N-1:0] read_port(input logic [AW-1:0] a);
        if (a == ZR_A)
            return '0;
        if ((BYPASS != 0) && wr4_ok && (wa4 == a))
            return wd4;
        if ((BYPASS != 0) && wr3_ok && (wa3 == a))
            return wd3;
        return regs[a];
    endfunction

    function automatic logic busy_port(input logic [AW-1:0] a);
        if (a == ZR_A)
            return 1'b0;
        // The producer's result is on the bus this cycle, so the hazard is already resolved.
        if ((BYPASS != 0) && ((wr4_ok && (wa4 == a)) || (wr3_ok && (wa3 == a))))
            return 1'b0;
        return sb[a];
    endfunction

    // Register array: port B is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REGS; i++)
                regs[i] <= (INIT_IDX != 0) ? N'(i) : '0;
        end else begin
            if (wr3_ok)
                regs[wa3] <= wd3;
            if (wr4_ok)
                regs[wa4] <= wd4;
        end
    end

    // Scoreboard: writes retire the producer, an issue on the same edge re-marks it busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb <= '0;
        end else begin
            if (wr3_ok)
                sb[wa3] <= 1'b0;
            if (wr4_ok)
                sb[wa4] <= 1'b0;
            if (iss_ok)
                sb[iss_a] <= 1'b1;
        end
    end

    // Combinational read data and busy flags for the three read ports.
    always_comb begin
        rd1   = read_port(ra1);
        rd2   = read_port(ra2);
        rd3   = read_port(ra3);
        busy1 = busy_port(ra1);
        busy2 = busy_port(ra2);
        busy3 = busy_port(ra3);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios on two 64x32 instances
// (A: forwarding, index reset values; B: no forwarding, zero reset values)
// plus a random run that also drives two 32x16 instances
// (C: forwarding, zero reset; D: no forwarding, index reset) against a model.
module tb_regfile_mp;

    logic clk;
    logic reset;

    logic [4:0]  ra_w [3];
    logic [4:0]  wa3_w, wa4_w, iss_a_w;
    logic [63:0] wd3_w, wd4_w;
    logic        we3_w, we4_w, iss_en_w;
    logic [63:0] rd_w [2][3];
    logic        busy_w [2][3];

    logic [3:0]  ra_n [3];
    logic [3:0]  wa3_n, wa4_n, iss_a_n;
    logic [31:0] wd3_n, wd4_n;
    logic        we3_n, we4_n, iss_en_n;
    logic [31:0] rd_n [2][3];
    logic        busy_n [2][3];

    logic [63:0] m_w [2][32];
    logic [31:0] sb_w;
    logic [31:0] m_n [2][16];
    logic [15:0] sb_n;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.N(64), .REGS(32), .BYPASS(1), .INIT_IDX(1)) dut_a (
        .clk(clk), .reset(reset),
        .ra1(ra_w[0]), .ra2(ra_w[1]), .ra3(ra_w[2]),
        .rd1(rd_w[0][0]), .rd2(rd_w[0][1]), .rd3(rd_w[0][2]),
        .busy1(busy_w[0][0]), .busy2(busy_w[0][1]), .busy3(busy_w[0][2]),
        .we3(we3_w), .wa3(wa3_w), .wd3(wd3_w),
        .we4(we4_w), .wa4(wa4_w), .wd4(wd4_w),
        .iss_en(iss_en_w), .iss_a(iss_a_w)
    );

    regfile_mp #(.N(64), .REGS(32), .BYPASS(0), .INIT_IDX(0)) dut_b (
        .clk(clk), .reset(reset),
        .ra1(ra_w[0]), .ra2(ra_w[1]), .ra3(ra_w[2]),
        .rd1(rd_w[1][0]), .rd2(rd_w[1][1]), .rd3(rd_w[1][2]),
        .busy1(busy_w[1][0]), .busy2(busy_w[1][1]), .busy3(busy_w[1][2]),
        .we3(we3_w), .wa3(wa3_w), .wd3(wd3_w),
        .we4(we4_w), .wa4(wa4_w), .wd4(wd4_w),
        .iss_en(iss_en_w), .iss_a(iss_a_w)
    );

    regfile_mp #(.N(32), .REGS(16), .BYPASS(1), .INIT_IDX(0)) dut_c (
        .clk(clk), .reset(reset),
        .ra1(ra_n[0]), .ra2(ra_n[1]), .ra3(ra_n[2]),
        .rd1(rd_n[0][0]), .rd2(rd_n[0][1]), .rd3(rd_n[0][2]),
        .busy1(busy_n[0][0]), .busy2(busy_n[0][1]), .busy3(busy_n[0][2]),
        .we3(we3_n), .wa3(wa3_n), .wd3(wd3_n),
        .we4(we4_n), .wa4(wa4_n), .wd4(wd4_n),
        .iss_en(iss_en_n), .iss_a(iss_a_n)
    );

    regfile_mp #(.N(32), .REGS(16), .BYPASS(0), .INIT_IDX(1)) dut_d (
        .clk(clk), .reset(reset),
        .ra1(ra_n[0]), .ra2(ra_n[1]), .ra3(ra_n[2]),
        .rd1(rd_n[1][0]), .rd2(rd_n[1][1]), .rd3(rd_n[1][2]),
        .busy1(busy_n[1][0]), .busy2(busy_n[1][1]), .busy3(busy_n[1][2]),
        .we3(we3_n), .wa3(wa3_n), .wd3(wd3_n),
        .we4(we4_n), .wa4(wa4_n), .wd4(wd4_n),
        .iss_en(iss_en_n), .iss_a(iss_a_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model read for the wide pair: index 0 forwards, index 1 does not.
    function automatic logic [63:0] exp_rd_w(input int d, input logic [4:0] a);
        if (a == 5'd31) return '0;
        if (d == 0 && we4_w && wa4_w != 5'd31 && wa4_w == a) return wd4_w;
        if (d == 0 && we3_w && wa3_w != 5'd31 && wa3_w == a) return wd3_w;
        return m_w[d][a];
    endfunction

    function automatic logic exp_busy_w(input int d, input logic [4:0] a);
        if (a == 5'd31) return 1'b0;
        if (d == 0 && ((we4_w && wa4_w == a) || (we3_w && wa3_w == a))) return 1'b0;
        return sb_w[a];
    endfunction

    function automatic logic [31:0] exp_rd_n(input int d, input logic [3:0] a);
        if (a == 4'd15) return '0;
        if (d == 0 && we4_n && wa4_n != 4'd15 && wa4_n == a) return wd4_n;
        if (d == 0 && we3_n && wa3_n != 4'd15 && wa3_n == a) return wd3_n;
        return m_n[d][a];
    endfunction

    function automatic logic exp_busy_n(input int d, input logic [3:0] a);
        if (a == 4'd15) return 1'b0;
        if (d == 0 && ((we4_n && wa4_n == a) || (we3_n && wa3_n == a))) return 1'b0;
        return sb_n[a];
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (we3_w && wa3_w != 5'd31) m_w[d][wa3_w] = wd3_w;
            if (we4_w && wa4_w != 5'd31) m_w[d][wa4_w] = wd4_w;
            if (we3_n && wa3_n != 4'd15) m_n[d][wa3_n] = wd3_n;
            if (we4_n && wa4_n != 4'd15) m_n[d][wa4_n] = wd4_n;
        end
        if (we3_w && wa3_w != 5'd31) sb_w[wa3_w] = 1'b0;
        if (we4_w && wa4_w != 5'd31) sb_w[wa4_w] = 1'b0;
        if (iss_en_w && iss_a_w != 5'd31) sb_w[iss_a_w] = 1'b1;
        if (we3_n && wa3_n != 4'd15) sb_n[wa3_n] = 1'b0;
        if (we4_n && wa4_n != 4'd15) sb_n[wa4_n] = 1'b0;
        if (iss_en_n && iss_a_n != 4'd15) sb_n[iss_a_n] = 1'b1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we3_w = 0; we4_w = 0; iss_en_w = 0;
        wa3_w = 0; wa4_w = 0; iss_a_w = 0; wd3_w = 0; wd4_w = 0;
        we3_n = 0; we4_n = 0; iss_en_n = 0;
        wa3_n = 0; wa4_n = 0; iss_a_n = 0; wd3_n = 0; wd4_n = 0;
        for (int k = 0; k < 3; k++) begin
            ra_w[k] = 0;
            ra_n[k] = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1;
        ra_w[0] = 5'd5; ra_w[1] = 5'd31; ra_w[2] = 5'd30;
        #2;
        checks++; if (rd_w[0][0] !== 64'd5) begin errors++; $display("FAIL reset_rd1_a: got %0d expected 5", rd_w[0][0]); end
        checks++; if (rd_w[0][1] !== 64'd0) begin errors++; $display("FAIL reset_rd2_zr_a: got %0d expected 0", rd_w[0][1]); end
        checks++; if (rd_w[0][2] !== 64'd30) begin errors++; $display("FAIL reset_rd3_a: got %0d expected 30", rd_w[0][2]); end
        checks++; if (rd_w[1][0] !== 64'd0) begin errors++; $display("FAIL reset_rd1_b: got %0d expected 0", rd_w[1][0]); end
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (busy_w[d][k] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d port%0d: got %b expected 0", d, k + 1, busy_w[d][k]); end
            end
        edge_step();
        reset = 0;
        #1;
        checks++; if (rd_w[0][0] !== 64'd5) begin errors++; $display("FAIL post_reset_rd1_a: got %0d expected 5", rd_w[0][0]); end
    endtask

    task automatic test_write_bypass();
        we3_w = 1; wa3_w = 5'd2; wd3_w = 64'd27; ra_w[0] = 5'd2;
        #1;
        checks++; if (rd_w[0][0] !== 64'd27) begin errors++; $display("FAIL bypass_pre_a: got %0d expected 27", rd_w[0][0]); end
        checks++; if (rd_w[1][0] !== 64'd0) begin errors++; $display("FAIL nobypass_pre_b: got %0d expected 0", rd_w[1][0]); end
        edge_step();
        we3_w = 0;
        #1;
        checks++; if (rd_w[0][0] !== 64'd27) begin errors++; $display("FAIL bypass_post_a: got %0d expected 27", rd_w[0][0]); end
        checks++; if (rd_w[1][0] !== 64'd27) begin errors++; $display("FAIL nobypass_post_b: got %0d expected 27", rd_w[1][0]); end
    endtask

    task automatic test_priority();
        we3_w = 1; wa3_w = 5'd7; wd3_w = 64'd35;
        we4_w = 1; wa4_w = 5'd7; wd4_w = 64'd52;
        ra_w[1] = 5'd7;
        #1;
        checks++; if (rd_w[0][1] !== 64'd52) begin errors++; $display("FAIL prio_pre_a: got %0d expected 52", rd_w[0][1]); end
        checks++; if (rd_w[1][1] !== 64'd0) begin errors++; $display("FAIL prio_pre_b: got %0d expected 0", rd_w[1][1]); end
        edge_step();
        we3_w = 0; we4_w = 0;
        #1;
        checks++; if (rd_w[0][1] !== 64'd52) begin errors++; $display("FAIL prio_post_a: got %0d expected 52", rd_w[0][1]); end
        checks++; if (rd_w[1][1] !== 64'd52) begin errors++; $display("FAIL prio_post_b: got %0d expected 52", rd_w[1][1]); end
        we4_w = 1; wa4_w = 5'd31; wd4_w = 64'd99; ra_w[2] = 5'd31;
        #1;
        checks++; if (rd_w[0][2] !== 64'd0) begin errors++; $display("FAIL zr_write_pre_a: got %0d expected 0", rd_w[0][2]); end
        edge_step();
        we4_w = 0;
        #1;
        checks++; if (rd_w[0][2] !== 64'd0) begin errors++; $display("FAIL zr_write_post_a: got %0d expected 0", rd_w[0][2]); end
        checks++; if (rd_w[1][2] !== 64'd0) begin errors++; $display("FAIL zr_write_post_b: got %0d expected 0", rd_w[1][2]); end
    endtask

    task automatic test_scoreboard();
        iss_en_w = 1; iss_a_w = 5'd9; ra_w[0] = 5'd9;
        #1;
        checks++; if (busy_w[0][0] !== 1'b0) begin errors++; $display("FAIL issue_same_cycle_a: got %b expected 0", busy_w[0][0]); end
        edge_step();
        iss_en_w = 0;
        #1;
        checks++; if (busy_w[0][0] !== 1'b1) begin errors++; $display("FAIL issue_busy_a: got %b expected 1", busy_w[0][0]); end
        checks++; if (busy_w[1][0] !== 1'b1) begin errors++; $display("FAIL issue_busy_b: got %b expected 1", busy_w[1][0]); end
        we3_w = 1; wa3_w = 5'd9; wd3_w = 64'd11;
        #1;
        checks++; if (busy_w[0][0] !== 1'b0) begin errors++; $display("FAIL wb_busy_bypass_a: got %b expected 0", busy_w[0][0]); end
        checks++; if (rd_w[0][0] !== 64'd11) begin errors++; $display("FAIL wb_rd_bypass_a: got %0d expected 11", rd_w[0][0]); end
        checks++; if (busy_w[1][0] !== 1'b1) begin errors++; $display("FAIL wb_busy_nobypass_b: got %b expected 1", busy_w[1][0]); end
        checks++; if (rd_w[1][0] !== 64'd0) begin errors++; $display("FAIL wb_rd_nobypass_b: got %0d expected 0", rd_w[1][0]); end
        edge_step();
        we3_w = 0;
        #1;
        checks++; if (busy_w[0][0] !== 1'b0) begin errors++; $display("FAIL wb_cleared_a: got %b expected 0", busy_w[0][0]); end
        checks++; if (busy_w[1][0] !== 1'b0) begin errors++; $display("FAIL wb_cleared_b: got %b expected 0", busy_w[1][0]); end
        checks++; if (rd_w[1][0] !== 64'd11) begin errors++; $display("FAIL wb_rd_post_b: got %0d expected 11", rd_w[1][0]); end
        iss_en_w = 1; iss_a_w = 5'd9; we4_w = 1; wa4_w = 5'd9; wd4_w = 64'd66;
        edge_step();
        iss_en_w = 0; we4_w = 0;
        #1;
        checks++; if (busy_w[0][0] !== 1'b1) begin errors++; $display("FAIL set_wins_a: got %b expected 1", busy_w[0][0]); end
        checks++; if (busy_w[1][0] !== 1'b1) begin errors++; $display("FAIL set_wins_b: got %b expected 1", busy_w[1][0]); end
        checks++; if (rd_w[1][0] !== 64'd66) begin errors++; $display("FAIL set_wins_rd_b: got %0d expected 66", rd_w[1][0]); end
        iss_en_w = 1; iss_a_w = 5'd31; ra_w[1] = 5'd31;
        edge_step();
        iss_en_w = 0;
        #1;
        checks++; if (busy_w[1][1] !== 1'b0) begin errors++; $display("FAIL issue_zr_b: got %b expected 0", busy_w[1][1]); end
    endtask

    task automatic test_reset_mid();
        we3_w = 1; wa3_w = 5'd4; wd3_w = 64'hDEAD; iss_en_w = 1; iss_a_w = 5'd4; ra_w[0] = 5'd4;
        edge_step();
        we3_w = 0; iss_en_w = 0;
        #1;
        checks++; if (rd_w[1][0] !== 64'hDEAD) begin errors++; $display("FAIL mid_rd_b: got %h expected dead", rd_w[1][0]); end
        checks++; if (busy_w[0][0] !== 1'b1) begin errors++; $display("FAIL mid_busy_a: got %b expected 1", busy_w[0][0]); end
        we4_w = 1; wa4_w = 5'd4; wd4_w = 64'hBEEF; iss_en_w = 1; iss_a_w = 5'd4;
        #1;
        checks++; if (rd_w[0][0] !== 64'hBEEF) begin errors++; $display("FAIL mid_bypass_a: got %h expected beef", rd_w[0][0]); end
        reset = 1;
        #1;
        checks++; if (rd_w[0][0] !== 64'd4) begin errors++; $display("FAIL rst_async_rd_a: got %h expected 4", rd_w[0][0]); end
        checks++; if (rd_w[1][0] !== 64'd0) begin errors++; $display("FAIL rst_async_rd_b: got %h expected 0", rd_w[1][0]); end
        checks++; if (busy_w[0][0] !== 1'b0) begin errors++; $display("FAIL rst_async_busy_a: got %b expected 0", busy_w[0][0]); end
        edge_step();
        reset = 0; we4_w = 0; iss_en_w = 0;
        #1;
        checks++; if (rd_w[0][0] !== 64'd4) begin errors++; $display("FAIL rst_drop_rd_a: got %h expected 4", rd_w[0][0]); end
        checks++; if (rd_w[1][0] !== 64'd0) begin errors++; $display("FAIL rst_drop_rd_b: got %h expected 0", rd_w[1][0]); end
        checks++; if (busy_w[1][0] !== 1'b0) begin errors++; $display("FAIL rst_drop_busy_b: got %b expected 0", busy_w[1][0]); end
    endtask

    task automatic test_random();
        idle_inputs();
        reset = 1;
        #1;
        for (int i = 0; i < 32; i++) begin
            m_w[0][i] = 64'(i);
            m_w[1][i] = '0;
        end
        for (int i = 0; i < 16; i++) begin
            m_n[0][i] = '0;
            m_n[1][i] = 32'(i);
        end
        sb_w = '0;
        sb_n = '0;
        edge_step();
        reset = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            // Half the addresses come from a narrow window near ZR to force collisions.
            we3_w = 1'($urandom_range(0, 1));
            we4_w = 1'($urandom_range(0, 1));
            iss_en_w = 1'($urandom_range(0, 1));
            wa3_w = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(27, 31));
            wa4_w = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(27, 31));
            iss_a_w = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(27, 31));
            wd3_w = {$urandom(), $urandom()};
            wd4_w = {$urandom(), $urandom()};
            we3_n = 1'($urandom_range(0, 1));
            we4_n = 1'($urandom_range(0, 1));
            iss_en_n = 1'($urandom_range(0, 1));
            wa3_n = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(12, 15));
            wa4_n = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(12, 15));
            iss_a_n = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(12, 15));
            wd3_n = $urandom();
            wd4_n = $urandom();
            for (int k = 0; k < 3; k++) begin
                ra_w[k] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(27, 31));
                ra_n[k] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(12, 15));
            end
            #1;
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (rd_w[d][k] !== exp_rd_w(d, ra_w[k])) begin
                        errors++;
                        $display("FAIL rand_rd_w dut%0d port%0d cycle %0d: got %h expected %h", d, k + 1, cyc, rd_w[d][k], exp_rd_w(d, ra_w[k]));
                    end
                    checks++;
                    if (busy_w[d][k] !== exp_busy_w(d, ra_w[k])) begin
                        errors++;
                        $display("FAIL rand_busy_w dut%0d port%0d cycle %0d: got %b expected %b", d, k + 1, cyc, busy_w[d][k], exp_busy_w(d, ra_w[k]));
                    end
                    checks++;
                    if (rd_n[d][k] !== exp_rd_n(d, ra_n[k])) begin
                        errors++;
                        $display("FAIL rand_rd_n dut%0d port%0d cycle %0d: got %h expected %h", d, k + 1, cyc, rd_n[d][k], exp_rd_n(d, ra_n[k]));
                    end
                    checks++;
                    if (busy_n[d][k] !== exp_busy_n(d, ra_n[k])) begin
                        errors++;
                        $display("FAIL rand_busy_n dut%0d port%0d cycle %0d: got %b expected %b", d, k + 1, cyc, busy_n[d][k], exp_busy_n(d, ra_n[k]));
                    end
                end
            @(posedge clk);
            model_edge();
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_write_bypass();
        test_priority();
        test_scoreboard();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
